// File: rtl/acc_seq_pkg.sv
// Shared types and default sizing for the accumulate sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_seq_pkg;

    localparam int DEF_INPUT_LENGTH  = 16;
    localparam int DEF_OUTPUT_LENGTH = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int COUNT_W           = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_GAP       = 3'd2;
    localparam logic [2:0] ST_TERM      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_RESULT    = 3'd5;

endpackage

// File: rtl/acc_seq_fifo.sv
// Synchronous FIFO holding {last, data} operands between producer and sequencer.
// Latency: a push is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: full blocks pushes, empty blocks pops; pointers carry an extra wrap bit.
module acc_seq_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers; the power-of-two depth makes the natural wrap a modulo.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer state, cleared by reset so the buffer comes back empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/accumulate_sequencer.sv
// Buffers operand batches and sequences accumulate/terminate commands to an accumulator, capturing each batch sum.
// Latency: 2 cycles from push edge to oAccumulate from IDLE; one GAP cycle between commands.
// Backpressure: oReadyIn drops when the buffer is full; commands wait for iAccReady. Option ACC_SEQ_COUNT_EN adds oCount.
module accumulate_sequencer
    import acc_seq_pkg::*;
#(
    parameter int INPUT_LENGTH  = DEF_INPUT_LENGTH,
    parameter int OUTPUT_LENGTH = DEF_OUTPUT_LENGTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [INPUT_LENGTH-1:0]  iData,
    input  logic                     iValid,
    input  logic                     iLast,
    output logic                     oReadyIn,
    output logic [INPUT_LENGTH-1:0]  oA,
    output logic                     oAccumulate,
    output logic                     oTerminate,
    input  logic                     iAccReady,
    input  logic                     iAccDone,
    input  logic [OUTPUT_LENGTH-1:0] iAccRes,
    output logic [OUTPUT_LENGTH-1:0] oRes,
    output logic                     oResValid,
    output logic                     oBusy
`ifdef ACC_SEQ_COUNT_EN
    ,
    output logic [COUNT_W-1:0]       oCount
`endif
);

    localparam int FW = INPUT_LENGTH + 1;

    state_t                   state_q, state_d;
    logic [INPUT_LENGTH-1:0]  a_q, a_d;
    logic                     last_q, last_d;
    logic                     acc_q, acc_d;
    logic                     term_q, term_d;
    logic [OUTPUT_LENGTH-1:0] res_q, res_d;
    logic                     res_vld_q, res_vld_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]            fifo_rdata;

    // Ready is held low while reset is asserted, then tracks buffer space.
    assign oReadyIn  = iRst & ~fifo_full;
    assign fifo_push = iValid & oReadyIn;
    assign fifo_pop  = (state_q == ST_ISSUE) & ~fifo_empty & iAccReady;

    acc_seq_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst),
        .push  (fifo_push),
        .wdata ({iLast, iData}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencing FSM: issue one operand per command, GAP between, terminate after the last.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        last_d    = last_q;
        acc_d     = 1'b0;
        term_d    = 1'b0;
        res_d     = res_q;
        res_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fifo_pop) begin
                    a_d     = fifo_rdata[INPUT_LENGTH-1:0];
                    last_d  = fifo_rdata[INPUT_LENGTH];
                    acc_d   = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = last_q ? ST_TERM : ST_ISSUE;
            end
            ST_TERM: begin
                if (iAccReady) begin
                    term_d  = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (iAccDone) begin
                    res_d     = iAccRes;
                    res_vld_d = 1'b1;
                    state_d   = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state and command outputs; reset drops any in-flight batch.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            last_q    <= 1'b0;
            acc_q     <= 1'b0;
            term_q    <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
            term_q    <= term_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign oA          = a_q;
    assign oAccumulate = acc_q;
    assign oTerminate  = term_q;
    assign oRes        = res_q;
    assign oResValid   = res_vld_q;
    assign oBusy       = (state_q != ST_IDLE) | ~fifo_empty;

`ifdef ACC_SEQ_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Operands issued in the current batch; cleared once the result is published.
    always_comb begin
        count_d = count_q;
        if (res_vld_q) begin
            count_d = '0;
        end else if (acc_d && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oCount = count_q;
`endif

endmodule

// File: tb/tb_accumulate_sequencer.sv
module tb_accumulate_sequencer;

    localparam int IW = 16;
    localparam int OW = 32;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic [IW-1:0] iData = '0;
    logic          iValid = 1'b0;
    logic          iLast = 1'b0;
    logic          iAccReady = 1'b1;
    logic          iAccDone = 1'b0;
    logic [OW-1:0] iAccRes = '0;
    logic          oReadyIn, oAccumulate, oTerminate, oResValid, oBusy;
    logic [IW-1:0] oA;
    logic [OW-1:0] oRes;
`ifdef ACC_SEQ_COUNT_EN
    logic [15:0]   oCount;
`endif

    accumulate_sequencer #(.INPUT_LENGTH(IW), .OUTPUT_LENGTH(OW), .FIFO_DEPTH(4)) dut (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .iLast(iLast),
        .oReadyIn(oReadyIn), .oA(oA), .oAccumulate(oAccumulate), .oTerminate(oTerminate),
        .iAccReady(iAccReady), .iAccDone(iAccDone), .iAccRes(iAccRes),
        .oRes(oRes), .oResValid(oResValid), .oBusy(oBusy)
`ifdef ACC_SEQ_COUNT_EN
        , .oCount(oCount)
`endif
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;
    int done_delay = 2;

    // Observation logs filled by the monitor
    logic [IW-1:0] acc_log[$];
    logic [OW-1:0] res_log[$];
    logic [15:0]   cnt_log[$];
    int            term_cnt = 0;
    bit            both_seen = 1'b0;

    // Accumulator model state
    logic [OW-1:0] acc_sum = '0;
    int            timer = 0;

    // Monitor: log every command and result seen on the outputs
    always @(negedge iClk) begin
        if (oAccumulate) begin
            acc_log.push_back(oA);
`ifdef ACC_SEQ_COUNT_EN
            cnt_log.push_back(oCount);
`endif
        end
        if (oTerminate) term_cnt++;
        if (oResValid) res_log.push_back(oRes);
        if (oAccumulate && oTerminate) both_seen = 1'b1;
    end

    // Accumulator model: sums operands, answers a terminate after done_delay cycles
    always @(negedge iClk) begin
        if (!iRst) begin
            acc_sum = '0;
            timer = 0;
            iAccDone = 1'b0;
        end else begin
            iAccDone = 1'b0;
            if (timer != 0) begin
                timer--;
                if (timer == 0) begin
                    iAccDone = 1'b1;
                    iAccRes = acc_sum;
                    acc_sum = '0;
                end
            end
            if (oAccumulate) acc_sum = acc_sum + OW'(oA);
            if (oTerminate) timer = done_delay;
        end
    end

    // Drive one operand; called at a negedge, returns at the negedge after acceptance
    task automatic push_word(input logic [IW-1:0] d, input logic l);
        int n;
        n = 0;
        iData = d;
        iLast = l;
        iValid = 1'b1;
        while (!oReadyIn && n < 300) begin
            @(negedge iClk);
            n++;
        end
        if (oReadyIn) begin
            @(negedge iClk);
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout: oReadyIn=%b after %0d cycles, need 1", oReadyIn, n);
        end
        iValid = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge iClk);
            n++;
            if (oResValid) break;
        end
        if (!oResValid) begin
            checks++;
            failures++;
            $display("FAIL wait_result: oResValid=0 after %0d cycles, need 1", budget);
        end
        @(negedge iClk);
    endtask

    task automatic test_reset();
        #3 iRst = 1'b0;
        repeat (2) @(negedge iClk);
        checks++; if (oReadyIn !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b need 0", oReadyIn); end
        checks++; if (oA !== '0) begin failures++; $display("FAIL rst_oA: got %h need 0", oA); end
        checks++; if (oRes !== '0) begin failures++; $display("FAIL rst_oRes: got %h need 0", oRes); end
        checks++; if (oAccumulate !== 1'b0) begin failures++; $display("FAIL rst_acc: got %b need 0", oAccumulate); end
        checks++; if (oTerminate !== 1'b0) begin failures++; $display("FAIL rst_term: got %b need 0", oTerminate); end
        checks++; if (oResValid !== 1'b0) begin failures++; $display("FAIL rst_resvld: got %b need 0", oResValid); end
        checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b need 0", oBusy); end
`ifdef ACC_SEQ_COUNT_EN
        checks++; if (oCount !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d need 0", oCount); end
`endif
        iRst = 1'b1;
        #1;
        checks++; if (oReadyIn !== 1'b1) begin failures++; $display("FAIL rel_ready: got %b need 1", oReadyIn); end
        @(negedge iClk);
    endtask

    task automatic test_latency();
        iAccReady = 1'b1;
        push_word(16'h1234, 1'b1);
        checks++; if (oAccumulate !== 1'b0) begin failures++; $display("FAIL lat_c0: got %b need 0", oAccumulate); end
        @(negedge iClk);
        checks++; if (oAccumulate !== 1'b0) begin failures++; $display("FAIL lat_c1: got %b need 0", oAccumulate); end
        @(negedge iClk);
        checks++; if (oAccumulate !== 1'b1 || oA !== 16'h1234) begin failures++; $display("FAIL lat_c2: got acc=%b a=%h need acc=1 a=1234", oAccumulate, oA); end
        wait_result(100);
        checks++; if (oRes !== 32'h1234) begin failures++; $display("FAIL lat_res: got %h need 00001234", oRes); end
    endtask

    task automatic test_batch4();
        logic [IW-1:0] w [4];
        int base, rbase, tbase, cbase;
        w = '{16'h0701, 16'h00F1, 16'h10B7, 16'hA2C1};
        base = acc_log.size(); rbase = res_log.size(); tbase = term_cnt; cbase = cnt_log.size();
        for (int i = 0; i < 4; i++) push_word(w[i], i == 3);
        wait_result(200);
`ifdef ACC_SEQ_COUNT_EN
        checks++; if (oCount !== 16'd0) begin failures++; $display("FAIL b4_count_clr: got %0d need 0", oCount); end
`endif
        repeat (3) @(negedge iClk);
        checks++; if (acc_log.size() - base != 4) begin failures++; $display("FAIL b4_npulse: got %0d need 4", acc_log.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (acc_log[base+i] !== w[i]) begin failures++; $display("FAIL b4_op%0d: got %h need %h", i, acc_log[base+i], w[i]); end
        end
        checks++; if (term_cnt - tbase != 1) begin failures++; $display("FAIL b4_nterm: got %0d need 1", term_cnt - tbase); end
        checks++; if (res_log.size() - rbase != 1) begin failures++; $display("FAIL b4_nres: got %0d need 1", res_log.size() - rbase); end
        checks++; if (oRes !== 32'h0000BB6A) begin failures++; $display("FAIL b4_sum: got %h need 0000BB6A", oRes); end
        checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL b4_busy: got %b need 0", oBusy); end
`ifdef ACC_SEQ_COUNT_EN
        checks++; if (cnt_log.size() - cbase != 4) begin failures++; $display("FAIL b4_ncount: got %0d need 4", cnt_log.size() - cbase); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (cnt_log[cbase+i] !== 16'(i + 1)) begin failures++; $display("FAIL b4_count%0d: got %0d need %0d", i, cnt_log[cbase+i], i + 1); end
        end
`endif
    endtask

    task automatic test_batch16();
        logic [IW-1:0] w [4];
        int base, tbase;
        w = '{16'h0701, 16'h00F1, 16'h10B7, 16'hA2C1};
        base = acc_log.size(); tbase = term_cnt;
        for (int i = 0; i < 16; i++) push_word(w[i % 4], i == 15);
        wait_result(400);
        checks++; if (acc_log.size() - base != 16) begin failures++; $display("FAIL b16_npulse: got %0d need 16", acc_log.size() - base); end
        else for (int i = 0; i < 16; i++) begin
            checks++; if (acc_log[base+i] !== w[i % 4]) begin failures++; $display("FAIL b16_op%0d: got %h need %h", i, acc_log[base+i], w[i % 4]); end
        end
        checks++; if (term_cnt - tbase != 1) begin failures++; $display("FAIL b16_nterm: got %0d need 1", term_cnt - tbase); end
        checks++; if (oRes !== 32'h0002EDA8) begin failures++; $display("FAIL b16_sum: got %h need 0002EDA8", oRes); end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] w [5];
        logic [OW-1:0] exp_sum;
        int base, seen;
        exp_sum = '0;
        for (int i = 0; i < 5; i++) begin
            w[i] = IW'($urandom);
            exp_sum = exp_sum + OW'(w[i]);
        end
        base = acc_log.size();
        iAccReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(w[i], 1'b0);
        checks++; if (oReadyIn !== 1'b0) begin failures++; $display("FAIL bp_full: oReadyIn got %b need 0", oReadyIn); end
        seen = 0;
        fork
            push_word(w[4], 1'b1);
            begin
                repeat (6) begin
                    @(negedge iClk);
                    if (oAccumulate) seen++;
                end
                checks++; if (seen != 0) begin failures++; $display("FAIL bp_noacc: got %0d pulses need 0", seen); end
                checks++; if (oReadyIn !== 1'b0) begin failures++; $display("FAIL bp_held: oReadyIn got %b need 0", oReadyIn); end
                iAccReady = 1'b1;
            end
        join
        wait_result(300);
        checks++; if (acc_log.size() - base != 5) begin failures++; $display("FAIL bp_npulse: got %0d need 5", acc_log.size() - base); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (acc_log[base+i] !== w[i]) begin failures++; $display("FAIL bp_op%0d: got %h need %h", i, acc_log[base+i], w[i]); end
        end
        checks++; if (oRes !== exp_sum) begin failures++; $display("FAIL bp_sum: got %h need %h", oRes, exp_sum); end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] w [7];
        logic [OW-1:0] sum_a, sum_b;
        int base, rbase, tbase, n, pulses;
        sum_a = '0; sum_b = '0;
        for (int i = 0; i < 7; i++) begin
            w[i] = IW'($urandom);
            if (i < 3) sum_a = sum_a + OW'(w[i]); else sum_b = sum_b + OW'(w[i]);
        end
        base = acc_log.size(); rbase = res_log.size(); tbase = term_cnt;
        done_delay = 8;
        for (int i = 0; i < 3; i++) push_word(w[i], i == 2);
        n = 0;
        while (!oTerminate && n < 100) begin @(negedge iClk); n++; end
        checks++; if (!oTerminate) begin failures++; $display("FAIL b2b_term: oTerminate got 0 need 1"); end
        for (int i = 3; i < 7; i++) push_word(w[i], i == 6);
        pulses = 0; n = 0;
        while (pulses < 2 && n < 300) begin
            @(negedge iClk);
            n++;
            if (oResValid) pulses++;
        end
        @(negedge iClk);
        done_delay = 2;
        checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_nres: got %0d need 2", pulses); end
        checks++; if (res_log.size() - rbase != 2) begin failures++; $display("FAIL b2b_nlog: got %0d need 2", res_log.size() - rbase); end
        else begin
            checks++; if (res_log[rbase] !== sum_a) begin failures++; $display("FAIL b2b_sum_a: got %h need %h", res_log[rbase], sum_a); end
            checks++; if (res_log[rbase+1] !== sum_b) begin failures++; $display("FAIL b2b_sum_b: got %h need %h", res_log[rbase+1], sum_b); end
        end
        checks++; if (term_cnt - tbase != 2) begin failures++; $display("FAIL b2b_nterm: got %0d need 2", term_cnt - tbase); end
        checks++; if (acc_log.size() - base != 7) begin failures++; $display("FAIL b2b_npulse: got %0d need 7", acc_log.size() - base); end
        else for (int i = 0; i < 7; i++) begin
            checks++; if (acc_log[base+i] !== w[i]) begin failures++; $display("FAIL b2b_op%0d: got %h need %h", i, acc_log[base+i], w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [IW-1:0] w [3];
        logic [OW-1:0] exp_sum;
        int base, rbase, tbase, k, n;
        base = acc_log.size(); rbase = res_log.size(); tbase = term_cnt;
        iAccReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(IW'($urandom), i == 3);
        iAccReady = 1'b1;
        k = 0; n = 0;
        while (k < 2 && n < 100) begin
            @(negedge iClk);
            n++;
            if (oAccumulate) k++;
        end
        checks++; if (k != 2) begin failures++; $display("FAIL rm_two_acc: got %0d need 2", k); end
        #2 iRst = 1'b0;
        #1;
        checks++; if (oA !== '0) begin failures++; $display("FAIL rm_oA: got %h need 0", oA); end
        checks++; if (oRes !== '0) begin failures++; $display("FAIL rm_oRes: got %h need 0", oRes); end
        checks++; if (oAccumulate !== 1'b0 || oTerminate !== 1'b0 || oResValid !== 1'b0) begin
            failures++; $display("FAIL rm_pulses: got acc=%b term=%b rv=%b need 0", oAccumulate, oTerminate, oResValid); end
        checks++; if (oBusy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b need 0", oBusy); end
        checks++; if (oReadyIn !== 1'b0) begin failures++; $display("FAIL rm_ready: got %b need 0", oReadyIn); end
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        repeat (10) @(negedge iClk);
        checks++; if (acc_log.size() - base != 2) begin failures++; $display("FAIL rm_npulse: got %0d need 2", acc_log.size() - base); end
        checks++; if (term_cnt != tbase) begin failures++; $display("FAIL rm_noterm: got %0d need 0", term_cnt - tbase); end
        checks++; if (res_log.size() != rbase) begin failures++; $display("FAIL rm_nores: got %0d need 0", res_log.size() - rbase); end
        checks++; if (oBusy !== 1'b0 || oReadyIn !== 1'b1) begin failures++; $display("FAIL rm_empty: got busy=%b rdy=%b need 0/1", oBusy, oReadyIn); end
        exp_sum = '0;
        base = acc_log.size();
        for (int i = 0; i < 3; i++) begin
            w[i] = IW'($urandom);
            exp_sum = exp_sum + OW'(w[i]);
            push_word(w[i], i == 2);
        end
        wait_result(200);
        checks++; if (oRes !== exp_sum) begin failures++; $display("FAIL rm_new_sum: got %h need %h", oRes, exp_sum); end
        checks++; if (acc_log.size() - base != 3) begin failures++; $display("FAIL rm_new_npulse: got %0d need 3", acc_log.size() - base); end
    endtask

    task automatic test_random();
        logic [IW-1:0] exp_words[$];
        logic [OW-1:0] exp_sums[$];
        logic [OW-1:0] s;
        logic [IW-1:0] d;
        int base, rbase, tbase, len, n;
        bit stop;
        base = acc_log.size(); rbase = res_log.size(); tbase = term_cnt;
        done_delay = $urandom_range(1, 4);
        stop = 1'b0;
        fork
            while (!stop) begin
                @(negedge iClk);
                iAccReady = ($urandom_range(0, 3) != 0);
            end
            begin
                for (int b = 0; b < 6; b++) begin
                    len = $urandom_range(1, 5);
                    s = '0;
                    for (int k = 0; k < len; k++) begin
                        d = IW'($urandom);
                        exp_words.push_back(d);
                        s = s + OW'(d);
                        push_word(d, k == len - 1);
                        repeat ($urandom_range(0, 2)) @(negedge iClk);
                    end
                    exp_sums.push_back(s);
                end
                n = 0;
                while (res_log.size() - rbase < 6 && n < 2000) begin @(negedge iClk); n++; end
                stop = 1'b1;
            end
        join
        iAccReady = 1'b1;
        done_delay = 2;
        repeat (2) @(negedge iClk);
        checks++; if (res_log.size() - rbase != 6) begin failures++; $display("FAIL rnd_nres: got %0d need 6", res_log.size() - rbase); end
        else for (int i = 0; i < 6; i++) begin
            checks++; if (res_log[rbase+i] !== exp_sums[i]) begin failures++; $display("FAIL rnd_sum%0d: got %h need %h", i, res_log[rbase+i], exp_sums[i]); end
        end
        checks++; if (term_cnt - tbase != 6) begin failures++; $display("FAIL rnd_nterm: got %0d need 6", term_cnt - tbase); end
        checks++; if (acc_log.size() - base != exp_words.size()) begin
            failures++; $display("FAIL rnd_npulse: got %0d need %0d", acc_log.size() - base, exp_words.size()); end
        else for (int i = 0; i < exp_words.size(); i++) begin
            checks++; if (acc_log[base+i] !== exp_words[i]) begin failures++; $display("FAIL rnd_op%0d: got %h need %h", i, acc_log[base+i], exp_words[i]); end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL acc_term_overlap: got %b need 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_batch4();
        test_batch16();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
